bcd_serial_unit: RTL

BCD_SERIAL_UNIT -- requirements
Module: bcd_serial_unit

---
 rtl/bcd_serial_unit_pkg.sv | 22 ++
 rtl/bcd_serial_unit_digit.sv | 54 +++++
 rtl/bcd_serial_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/bcd_serial_unit_pkg.sv
// Shared definitions for the serial BCD add/subtract unit.
// Optional feature macro: DECIMAL_SUB_EN (decimal subtract support).
package bcd_serial_unit_pkg;

  // Controller state encodings
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADJUST = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Number of 4-bit digits processed for a given data width
  function automatic int num_digits(input int dw);
    return dw / 4;
  endfunction

  // Counter width able to index every digit (at least one bit)
  function automatic int cnt_width(input int dw);
    return (num_digits(dw) > 1) ? $clog2(num_digits(dw)) : 1;
  endfunction

endpackage

// File: rtl/bcd_serial_unit_digit.sv
// Single-digit BCD adder/subtractor, purely combinational.
// Optional feature macro: DECIMAL_SUB_EN (subtract path present only when defined).
module bcd_digit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  input  logic       sub,
  output logic [3:0] digit,
  output logic       cout
);

  // 5-bit binary digit sum; carry-in folded in
  logic [4:0] s;
  assign s = {1'b0, a} + {1'b0, b} + {4'b0, c};

`ifdef DECIMAL_SUB_EN
  // 6-bit signed difference; c is the not-borrow in, so borrow = ~c
  logic [5:0] d;
  assign d = {2'b0, a} - {2'b0, b} - {5'b0, ~c};

  // Select add or subtract result with decimal adjust
  always_comb begin
    digit = s[3:0];
    cout  = 1'b0;
    if (sub) begin
      if (d[5]) begin
        digit = d[3:0] - 4'd6;
        cout  = 1'b0;
      end else begin
        digit = d[3:0];
        cout  = 1'b1;
      end
    end else if (s > 5'd9) begin
      digit = s[3:0] + 4'd6;
      cout  = 1'b1;
    end
  end
`else
  // Subtract disabled: operation select is ignored
  logic sub_unused;
  assign sub_unused = sub;

  // Decimal-adjusted add
  always_comb begin
    digit = s[3:0];
    cout  = 1'b0;
    if (s > 5'd9) begin
      digit = s[3:0] + 4'd6;
      cout  = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/bcd_serial_unit.sv
// Serial BCD arithmetic unit: one digit per enabled cycle, LSB digit first.
// Optional feature macro: DECIMAL_SUB_EN (adds the sub port and decimal subtract).
module bcd_serial_unit
  import bcd_serial_unit_pkg::*;
#(
  parameter int dw = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RDY,
  input  logic          start,
`ifdef DECIMAL_SUB_EN
  input  logic          sub,
`endif
  input  logic [dw-1:0] AI,
  input  logic [dw-1:0] BI,
  input  logic          CI,
  output logic [dw-1:0] OUT,
  output logic          CO,
  output logic          V,
  output logic          Z,
  output logic          N,
  output logic          busy,
  output logic          done
);

  localparam int ND = num_digits(dw);
  localparam int CW = cnt_width(dw);
  localparam logic [CW-1:0] LAST = CW'(ND - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [dw-1:0] a_sh, b_sh, res;
  logic          carry;
  logic          v_pend;

  // Operation select at the inputs and as latched for the running op
  logic sub_in;
  logic sub_q;
`ifdef DECIMAL_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
  assign sub_q  = 1'b0;
`endif

  // Overflow is a property of the binary sum, so it is taken from the
  // operands at acceptance and parked until the result is published
  logic [dw-1:0] x_op, bin_sum;
  logic          v_in;
  assign x_op    = sub_in ? ~BI : BI;
  assign bin_sum = AI + x_op + {{(dw-1){1'b0}}, CI};
  assign v_in    = (AI[dw-1] == x_op[dw-1]) & (bin_sum[dw-1] != AI[dw-1]);

  // Digit datapath: low nibble of the shifting operands
  logic [3:0]    dig;
  logic          dig_c;
  logic [dw-1:0] new_res;

  bcd_digit u_digit (
    .a     (a_sh[3:0]),
    .b     (b_sh[3:0]),
    .c     (carry),
    .sub   (sub_q),
    .digit (dig),
    .cout  (dig_c)
  );

  // Result fills from the top so the first digit ends at bit 0
  assign new_res = {dig, res[dw-1:4]};

  // Controller, datapath registers and published outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      v_pend <= 1'b0;
`ifdef DECIMAL_SUB_EN
      sub_q  <= 1'b0;
`endif
      OUT    <= '0;
      CO     <= 1'b0;
      V      <= 1'b0;
      Z      <= 1'b1;
      N      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (RDY) begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= ADJUST;
            cnt    <= '0;
            a_sh   <= AI;
            b_sh   <= BI;
            carry  <= CI;
            v_pend <= v_in;
`ifdef DECIMAL_SUB_EN
            sub_q  <= sub_in;
`endif
            busy   <= 1'b1;
            done   <= 1'b0;
          end else begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        ADJUST: begin
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          res   <= new_res;
          carry <= dig_c;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            OUT   <= new_res;
            CO    <= dig_c;
            V     <= v_pend;
            Z     <= (new_res == '0);
            N     <= new_res[dw-1];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
